// File: rtl/control_pipe.sv
// control_pipe: ID decode plus ID->EX->MEM->WB control bundle registers,
// load-use hazard detection and operand-forward select generation.
// Build option: define CONTROL_PIPE_FWD_EN to enable operand forwarding.
// Without it, fwd_a/fwd_b are tied to 00 and any RAW dependence on an EX or
// MEM writer stalls instead.
module control_pipe #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned IMM_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              id_valid,
    input  logic              LE,
    input  logic              flush,
    output logic              id_branch,
    output logic              id_call,
    output logic              id_jmpl,
    output logic              hazard_stall,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_psr_en,
    output logic [IMM_W-1:0]  ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_load,
    output logic              mem_ram_en,
    output logic              mem_ram_rw,
    output logic [1:0]        mem_ram_size,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_rf_le,
    output logic              wb_rf_le,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        wb_sel,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam int unsigned OPC_W   = 8;
    localparam int unsigned RS1_LSB = 19;
    localparam int unsigned RS2_LSB = 14;

    localparam logic [OPC_W-1:0] OPC_ADD   = 8'h8A;
    localparam logic [OPC_W-1:0] OPC_SUBCC = 8'h86;
    localparam logic [OPC_W-1:0] OPC_LDUB  = 8'hC4;
    localparam logic [OPC_W-1:0] OPC_STB   = 8'hCA;
    localparam logic [OPC_W-1:0] OPC_BNE   = 8'h12;
    localparam logic [OPC_W-1:0] OPC_SETHI = 8'h0B;
    localparam logic [OPC_W-1:0] OPC_CALL  = 8'h40;
    localparam logic [OPC_W-1:0] OPC_JMPL  = 8'h81;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_CALL = 2'b10;
    localparam logic [1:0] SEL_JMPL = 2'b11;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SETHI = 4'd5;

    localparam int unsigned CALL_RD = 15;

    // Control bundle latched into EX; fields for later stages ride along.
    typedef struct packed {
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              psr_en;
        logic [IMM_W-1:0]  imm;
        logic [REG_AW-1:0] rd;
        logic              load;
        logic              rf_le;
        logic              ram_en;
        logic              ram_rw;
        logic [1:0]        ram_size;
        logic [1:0]        wb_sel;
    } ex_bundle_t;

    typedef struct packed {
        logic              ram_en;
        logic              ram_rw;
        logic [1:0]        ram_size;
        logic [REG_AW-1:0] rd;
        logic              rf_le;
        logic [1:0]        wb_sel;
    } mem_bundle_t;

    typedef struct packed {
        logic              rf_le;
        logic [REG_AW-1:0] rd;
        logic [1:0]        wb_sel;
    } wb_bundle_t;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd_field;
    logic              uses_rs2;
    ex_bundle_t        dec;
    ex_bundle_t        ex_d, ex_q;
    mem_bundle_t       mem_d, mem_q;
    wb_bundle_t        wb_d, wb_q;
    logic              rs1_hit_ex;
    logic              rs2_hit_ex;
    logic              bubble;

    // A destination of r0 never creates a dependence.
    function automatic logic rd_hit(input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

    assign opcode   = instr[31:24];
    assign rs1      = instr[RS1_LSB +: REG_AW];
    assign rs2      = instr[RS2_LSB +: REG_AW];
    assign rd_field = instr[REG_AW-1:0];

    // ID decode into an EX bundle plus combinational control-transfer flags.
    always_comb begin
        dec       = '0;
        id_branch = 1'b0;
        id_call   = 1'b0;
        id_jmpl   = 1'b0;
        uses_rs2  = 1'b0;
        dec.rd    = rd_field;
        dec.imm   = IMM_W'($signed(instr[15:0]));
        unique case (opcode)
            OPC_ADD: begin
                dec.alu_op = ALU_ADD;
                dec.rf_le  = 1'b1;
                uses_rs2   = 1'b1;
            end
            OPC_SUBCC: begin
                dec.alu_op  = ALU_SUB;
                dec.alu_src = 1'b1;
                dec.psr_en  = 1'b1;
                dec.rf_le   = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_LDUB: begin
                dec.alu_src  = 1'b1;
                dec.load     = 1'b1;
                dec.ram_en   = 1'b1;
                dec.ram_size = 2'b01;
                dec.ram_rw   = 1'b0;
                dec.rf_le    = 1'b1;
                dec.wb_sel   = SEL_LOAD;
            end
            OPC_STB: begin
                dec.alu_src  = 1'b1;
                dec.ram_en   = 1'b1;
                dec.ram_size = 2'b01;
                dec.ram_rw   = 1'b1;
                uses_rs2     = 1'b1;
            end
            OPC_BNE: begin
                id_branch = id_valid;
            end
            OPC_SETHI: begin
                dec.alu_op  = ALU_SETHI;
                dec.alu_src = 1'b1;
                dec.rf_le   = 1'b1;
                dec.imm     = IMM_W'({instr[21:0], 10'b0});
            end
            OPC_CALL: begin
                id_call    = id_valid;
                dec.rf_le  = 1'b1;
                dec.rd     = REG_AW'(CALL_RD);
                dec.wb_sel = SEL_CALL;
            end
            OPC_JMPL: begin
                id_jmpl    = id_valid;
                dec.wb_sel = SEL_JMPL;
                dec.rf_le  = (rd_field != '0);
            end
            default: begin
                dec = '0;
            end
        endcase
    end

    assign rs1_hit_ex = rd_hit(ex_q.rd, rs1);
    assign rs2_hit_ex = uses_rs2 && rd_hit(ex_q.rd, rs2);

    // Stall detection: load-use always; without forwarding, any EX/MEM RAW too.
    always_comb begin
        hazard_stall = 1'b0;
        if (id_valid) begin
            hazard_stall = ex_q.load && (rs1_hit_ex || rs2_hit_ex);
`ifndef CONTROL_PIPE_FWD_EN
            if (ex_q.rf_le && (rs1_hit_ex || rs2_hit_ex)) begin
                hazard_stall = 1'b1;
            end
            if (mem_q.rf_le &&
                (rd_hit(mem_q.rd, rs1) || (uses_rs2 && rd_hit(mem_q.rd, rs2)))) begin
                hazard_stall = 1'b1;
            end
`endif
        end
    end

`ifdef CONTROL_PIPE_FWD_EN
    // Forward source for one operand; nearest producer wins.
    function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (ex_q.rf_le && !ex_q.load && rd_hit(ex_q.rd, rs)) begin
            sel = FWD_EX;
        end else if (mem_q.rf_le && rd_hit(mem_q.rd, rs)) begin
            sel = FWD_MEM;
        end else if (wb_q.rf_le && rd_hit(wb_q.rd, rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Operand-forward selects, evaluated every cycle regardless of LE.
    always_comb begin
        fwd_a = fwd_pick(rs1);
        fwd_b = fwd_pick(rs2);
    end
`else
    // Forwarding absent: operands always come from the register file.
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
    end
`endif

    // Next-state for each stage; a squashed or stalled ID becomes a bubble.
    always_comb begin
        bubble = !id_valid || flush || hazard_stall;
        ex_d   = bubble ? '0 : dec;

        mem_d          = '0;
        mem_d.ram_en   = ex_q.ram_en;
        mem_d.ram_rw   = ex_q.ram_rw;
        mem_d.ram_size = ex_q.ram_size;
        mem_d.rd       = ex_q.rd;
        mem_d.rf_le    = ex_q.rf_le;
        mem_d.wb_sel   = ex_q.wb_sel;

        wb_d        = '0;
        wb_d.rf_le  = mem_q.rf_le;
        wb_d.rd     = mem_q.rd;
        wb_d.wb_sel = mem_q.wb_sel;
    end

    // Stage registers: synchronous clear, otherwise advance only when LE=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (LE) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_psr_en    = ex_q.psr_en;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_load      = ex_q.load;
    assign mem_ram_en   = mem_q.ram_en;
    assign mem_ram_rw   = mem_q.ram_rw;
    assign mem_ram_size = mem_q.ram_size;
    assign mem_rd       = mem_q.rd;
    assign mem_rf_le    = mem_q.rf_le;
    assign wb_rf_le     = wb_q.rf_le;
    assign wb_rd        = wb_q.rd;
    assign wb_sel       = wb_q.wb_sel;

endmodule
